mem_port_ctrl: RTL and testbench

Cycle-registered request/response front end between the multi-cycle MIPS core and the dual-read, single-write ideal memory. It gives the core an instruction channel on read port 1 and a data channel on read port 2 plus the write port. Both channels use valid/ready handshakes. Responses are registered. Partial (byte-strobed) stores are built from word-only memory writes using read-modify-write.

---
 rtl/mips_mem_pkg.sv | 20 ++
 rtl/mem_byte_merge.sv | 18 +
 rtl/mem_port_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared state encodings and constants for the MIPS memory port controller.
package mips_mem_pkg;

  typedef enum logic {
    IIdle = 1'b0,
    IResp = 1'b1
  } inst_state_e;

  typedef enum logic [1:0] {
    DIdle = 2'd0,
    DRmw  = 2'd1,
    DResp = 2'd2
  } data_state_e;

  // Byte-address bits dropped when forming a memory word address.
  localparam int unsigned WordLsb = 2;

  localparam logic [3:0] FullStrb = 4'hf;

endpackage

// File: rtl/mem_byte_merge.sv
// Per-byte merge of a new store word into an old memory word under a byte strobe.
module mem_byte_merge (
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  strb_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    for (int b = 0; b < 4; b++) begin
      if (strb_i[b]) begin
        merged_o[8*b +: 8] = new_word_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// Instruction/data valid-ready front end onto a dual-read, single-write word memory.
// MEM_PORT_CTRL_RMW_EN enables byte-strobed stores via read-modify-write.
module mem_port_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_req_valid,
  output logic                  inst_req_ready,
  input  logic [31:0]           inst_addr,
  output logic                  inst_resp_valid,
  input  logic                  inst_resp_ready,
  output logic [31:0]           inst_rdata,
  input  logic                  data_req_valid,
  output logic                  data_req_ready,
  input  logic [31:0]           data_addr,
  input  logic                  data_wen,
  input  logic [3:0]            data_wstrb,
  input  logic [31:0]           data_wdata,
  output logic                  data_resp_valid,
  input  logic                  data_resp_ready,
  output logic [31:0]           data_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr1,
  output logic [ADDR_WIDTH-1:0] mem_raddr2,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_rden1,
  output logic                  mem_rden2,
  output logic                  mem_wren,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata1,
  input  logic [31:0]           mem_rdata2
);

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [31:0] byte_addr);
    return {{WordLsb{1'b0}}, byte_addr[ADDR_WIDTH-1:WordLsb]};
  endfunction

  inst_state_e inst_state_q, inst_state_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  data_state_e data_state_q, data_state_d;
  logic [31:0] data_rdata_q, data_rdata_d;

`ifdef MEM_PORT_CTRL_RMW_EN
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]           pend_wdata_q, pend_wdata_d;
  logic [3:0]            pend_strb_q, pend_strb_d;
  logic [31:0]           merged_word;

  mem_byte_merge u_byte_merge (
    .old_word_i (mem_rdata2),
    .new_word_i (pend_wdata_q),
    .strb_i     (pend_strb_q),
    .merged_o   (merged_word)
  );
`endif

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
`ifdef MEM_PORT_CTRL_RMW_EN
  assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH], inst_addr[WordLsb-1:0],
                              data_addr[31:ADDR_WIDTH], data_addr[WordLsb-1:0]};
`else
  assign unused_addr_bits = ^{inst_addr[31:ADDR_WIDTH], inst_addr[WordLsb-1:0],
                              data_addr[31:ADDR_WIDTH], data_addr[WordLsb-1:0], data_wstrb};
`endif

  // Instruction channel
  always_comb begin
    inst_state_d    = inst_state_q;
    inst_rdata_d    = inst_rdata_q;
    inst_req_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    mem_rden1       = 1'b0;
    mem_raddr1      = '0;
    if (!rst) begin
      case (inst_state_q)
        IIdle: begin
          inst_req_ready = 1'b1;
          mem_rden1      = inst_req_valid;
          mem_raddr1     = word_addr(inst_addr);
          if (inst_req_valid) begin
            inst_rdata_d = mem_rdata1;
            inst_state_d = IResp;
          end
        end
        IResp: begin
          inst_resp_valid = 1'b1;
          if (inst_resp_ready) begin
            inst_state_d = IIdle;
          end
        end
        default: inst_state_d = IIdle;
      endcase
    end
  end

  // Data channel
  always_comb begin
    data_state_d    = data_state_q;
    data_rdata_d    = data_rdata_q;
    data_req_ready  = 1'b0;
    data_resp_valid = 1'b0;
    mem_rden2       = 1'b0;
    mem_raddr2      = '0;
    mem_wren        = 1'b0;
    mem_waddr       = '0;
    mem_wdata       = '0;
`ifdef MEM_PORT_CTRL_RMW_EN
    pend_addr_d     = pend_addr_q;
    pend_wdata_d    = pend_wdata_q;
    pend_strb_d     = pend_strb_q;
`endif
    if (!rst) begin
      case (data_state_q)
        DIdle: begin
          data_req_ready = 1'b1;
          if (data_req_valid) begin
            if (!data_wen) begin
              mem_rden2    = 1'b1;
              mem_raddr2   = word_addr(data_addr);
              data_rdata_d = mem_rdata2;
              data_state_d = DResp;
`ifdef MEM_PORT_CTRL_RMW_EN
            end else if (data_wstrb != FullStrb) begin
              pend_addr_d  = word_addr(data_addr);
              pend_wdata_d = data_wdata;
              pend_strb_d  = data_wstrb;
              data_state_d = DRmw;
`endif
            end else begin
              mem_wren     = 1'b1;
              mem_waddr    = word_addr(data_addr);
              mem_wdata    = data_wdata;
              data_rdata_d = data_wdata;
              data_state_d = DResp;
            end
          end
        end
`ifdef MEM_PORT_CTRL_RMW_EN
        DRmw: begin
          mem_rden2  = 1'b1;
          mem_raddr2 = pend_addr_q;
          // An empty strobe still responds, but leaves memory untouched.
          if (pend_strb_q != '0) begin
            mem_wren  = 1'b1;
            mem_waddr = pend_addr_q;
            mem_wdata = merged_word;
          end
          data_rdata_d = merged_word;
          data_state_d = DResp;
        end
`endif
        DResp: begin
          data_resp_valid = 1'b1;
          if (data_resp_ready) begin
            data_state_d = DIdle;
          end
        end
        default: data_state_d = DIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_state_q <= IIdle;
      inst_rdata_q <= '0;
      data_state_q <= DIdle;
      data_rdata_q <= '0;
    end else begin
      inst_state_q <= inst_state_d;
      inst_rdata_q <= inst_rdata_d;
      data_state_q <= data_state_d;
      data_rdata_q <= data_rdata_d;
    end
  end

`ifdef MEM_PORT_CTRL_RMW_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      pend_strb_q  <= '0;
    end else begin
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      pend_strb_q  <= pend_strb_d;
    end
  end
`endif

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Randomized self-checking bench for mem_port_ctrl against a word-level memory model.
module tb_mem_port_ctrl;

  localparam int unsigned AW = 10;
`ifdef MEM_PORT_CTRL_RMW_EN
  localparam bit Rmw = 1'b1;
`else
  localparam bit Rmw = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_req_valid = 1'b0, inst_req_ready, inst_resp_valid, inst_resp_ready = 1'b0;
  logic [31:0]   inst_addr = '0, inst_rdata;
  logic          data_req_valid = 1'b0, data_req_ready, data_wen = 1'b0;
  logic [3:0]    data_wstrb = '0;
  logic [31:0]   data_addr = '0, data_wdata = '0, data_rdata;
  logic          data_resp_valid, data_resp_ready = 1'b0;
  logic [AW-1:0] mem_raddr1, mem_raddr2, mem_waddr;
  logic          mem_rden1, mem_rden2, mem_wren;
  logic [31:0]   mem_wdata, mem_rdata1, mem_rdata2;

  mem_port_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_addr       (inst_addr),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_ready (inst_resp_ready),
    .inst_rdata      (inst_rdata),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_addr       (data_addr),
    .data_wen        (data_wen),
    .data_wstrb      (data_wstrb),
    .data_wdata      (data_wdata),
    .data_resp_valid (data_resp_valid),
    .data_resp_ready (data_resp_ready),
    .data_rdata      (data_rdata),
    .mem_raddr1      (mem_raddr1),
    .mem_raddr2      (mem_raddr2),
    .mem_waddr       (mem_waddr),
    .mem_rden1       (mem_rden1),
    .mem_rden2       (mem_rden2),
    .mem_wren        (mem_wren),
    .mem_wdata       (mem_wdata),
    .mem_rdata1      (mem_rdata1),
    .mem_rdata2      (mem_rdata2)
  );

  always #5 clk = ~clk;

  // Ideal memory with a backdoor preload port; model[] holds the expected contents.
  logic [31:0]   mem [1024];
  logic [31:0]   model [256];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  int            wr_total = 0;
  logic [AW-1:0] last_waddr = '0;

  assign mem_rdata1 = mem[mem_raddr1];
  assign mem_rdata2 = mem[mem_raddr2];

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    if (mem_wren) begin
      mem[mem_waddr] <= mem_wdata;
      wr_total       <= wr_total + 1;
      last_waddr     <= mem_waddr;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = AW'(idx); bd_data = d;
    model[idx] = d;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  // One transaction on either or both channels, accepted in the same cycle.
  task automatic txn(input bit do_i, input logic [31:0] ia, input bit do_d, input bit wen,
                     input logic [31:0] da, input logic [3:0] strb, input logic [31:0] wd,
                     input int hold);
    logic [31:0] i_exp, d_exp, old;
    int          d_lat_exp, wr_exp, lat, wr_base, di;
    i_exp = model[ia[9:2]];
    di    = int'(da[9:2]);
    old   = model[di];
    if (!wen) begin
      d_exp = old; d_lat_exp = 1; wr_exp = 0;
    end else if (Rmw && strb != 4'hf) begin
      d_exp = merge(old, wd, strb); d_lat_exp = 2; wr_exp = (strb != 4'h0) ? 1 : 0;
    end else begin
      d_exp = wd; d_lat_exp = 1; wr_exp = 1;
    end
    if (!do_d) wr_exp = 0;
    if (do_d && wen) model[di] = d_exp;

    @(negedge clk);
    inst_req_valid = do_i; inst_addr = ia;
    data_req_valid = do_d; data_wen = wen; data_addr = da; data_wstrb = strb; data_wdata = wd;
    #1;
    if (do_i) begin
      check_eq("i_req_ready", inst_req_ready, 1);
      check_eq("i_rden", mem_rden1, 1);
      check_eq("i_raddr", mem_raddr1, {2'b00, ia[9:2]});
    end
    if (do_d) check_eq("d_req_ready", data_req_ready, 1);
    wr_base = wr_total;
    @(posedge clk); #1;
    inst_req_valid = 1'b0; data_req_valid = 1'b0;
    if (do_i) begin
      check_eq("i_resp_valid", inst_resp_valid, 1);
      check_eq("i_rdata", inst_rdata, i_exp);
      check_eq("i_busy_ready", inst_req_ready, 0);
    end
    if (do_d) begin
      lat = 1;
      while (data_resp_valid !== 1'b1 && lat < 8) begin
        @(posedge clk); #1;
        lat++;
      end
      check_eq("d_latency", lat, d_lat_exp);
      check_eq("d_rdata", data_rdata, d_exp);
      check_eq("d_busy_ready", data_req_ready, 0);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (do_i) begin
      check_eq("i_hold_valid", inst_resp_valid, 1);
      check_eq("i_hold_rdata", inst_rdata, i_exp);
    end
    if (do_d) begin
      check_eq("d_hold_valid", data_resp_valid, 1);
      check_eq("d_hold_rdata", data_rdata, d_exp);
    end
    @(negedge clk);
    inst_resp_ready = do_i; data_resp_ready = do_d;
    @(posedge clk); #1;
    inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
    check_eq("i_resp_done", inst_resp_valid, 0);
    check_eq("d_resp_done", data_resp_valid, 0);
    check_eq("write_count", wr_total - wr_base, wr_exp);
    if (wr_exp != 0) check_eq("waddr", last_waddr, di);
  endtask

  // Data request accepted, then reset asserted in the following cycle.
  task automatic rst_mid(input bit wen, input logic [31:0] da, input logic [3:0] strb,
                         input logic [31:0] wd);
    int wr_base, wr_exp;
    wr_exp = (wen && (!Rmw || strb == 4'hf)) ? 1 : 0;
    if (wr_exp != 0) model[da[9:2]] = wd;
    @(negedge clk);
    data_req_valid = 1'b1; data_wen = wen; data_addr = da; data_wstrb = strb; data_wdata = wd;
    inst_req_valid = 1'b1; inst_addr = da;
    wr_base = wr_total;
    @(posedge clk); #1;
    data_req_valid = 1'b0; inst_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_wren", mem_wren, 0);
    check_eq("rst_d_ready", data_req_ready, 0);
    check_eq("rst_i_ready", inst_req_ready, 0);
    check_eq("rst_d_valid", data_resp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("post_rst_d_valid", data_resp_valid, 0);
    check_eq("post_rst_i_valid", inst_resp_valid, 0);
    check_eq("post_rst_d_rdata", data_rdata, 0);
    check_eq("post_rst_i_rdata", inst_rdata, 0);
    check_eq("post_rst_d_ready", data_req_ready, 1);
    check_eq("post_rst_i_ready", inst_req_ready, 1);
    check_eq("rst_write_count", wr_total - wr_base, wr_exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Preload under reset; outputs must stay at reset values throughout.
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(2, 32'h2402000A);
    @(negedge clk); #1;
    check_eq("reset_i_ready", inst_req_ready, 0);
    check_eq("reset_d_ready", data_req_ready, 0);
    check_eq("reset_i_valid", inst_resp_valid, 0);
    check_eq("reset_d_valid", data_resp_valid, 0);
    check_eq("reset_i_rdata", inst_rdata, 0);
    check_eq("reset_d_rdata", data_rdata, 0);
    check_eq("reset_wren", mem_wren, 0);
    rst = 1'b0;
    #1;
    check_eq("idle_i_ready", inst_req_ready, 1);
    check_eq("idle_d_ready", data_req_ready, 1);

    txn(1, 32'h0000_0008, 0, 0, 0, 0, 0, 3);
    txn(0, 0, 1, 1, 32'h0000_0064, 4'hf, 32'hDEADBEEF, 0);
    txn(0, 0, 1, 0, 32'h0000_0064, 4'h0, 0, 1);
    txn(0, 0, 1, 1, 32'h0000_0064, 4'hf, 32'h11223344, 0);
    txn(0, 0, 1, 1, 32'h0000_0064, 4'b0010, 32'h0000AB00, 2);
    check_eq("partial_word", model[25], Rmw ? 32'h1122AB44 : 32'h0000AB00);
    txn(0, 0, 1, 1, 32'h0000_0064, 4'hf, 32'h11223344, 0);
    txn(1, 32'h0000_0064, 1, 1, 32'h0000_0064, 4'hf, 32'h0000_0055, 1);
    txn(0, 0, 1, 0, 32'h0000_0064, 4'h0, 0, 0);
    txn(0, 0, 1, 1, 32'h0000_0064, 4'h0, 32'hFFFFFFFF, 0);
    txn(0, 0, 1, 0, 32'h0000_0064, 4'h0, 0, 0);
    rst_mid(1, 32'h0000_0064, 4'b0100, 32'h00CC0000);
    rst_mid(0, 32'h0000_0010, 4'h0, 0);
    rst_mid(1, 32'h0000_0020, 4'hf, 32'hA5A5A5A5);

    for (int n = 0; n < 300; n++) begin
      int          op;
      logic [3:0]  s;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      a  = $urandom;
      s  = ($urandom_range(0, 1) == 0) ? 4'hf : 4'($urandom);
      case (op)
        0:       txn(1, $urandom, 0, 0, 0, 0, 0, $urandom_range(0, 2));
        1:       txn(0, 0, 1, 0, a, 0, 0, $urandom_range(0, 2));
        2:       txn(0, 0, 1, 1, a, s, $urandom, $urandom_range(0, 2));
        default: txn(1, ($urandom_range(0, 1) == 0) ? a : $urandom, 1,
                     1'($urandom), a, s, $urandom, $urandom_range(0, 2));
      endcase
    end

    @(negedge clk);
    for (int i = 0; i < 256; i++) check_eq("mem_word", mem[i], model[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
